// File: rtl/dice_pkg.sv
// Shared encodings for the dice game: turn states, winner codes, die range.
// Imported by the scorekeeper datapath and the turn state machine.
package dice_pkg;

    typedef enum logic [1:0] {
        ST_POWEROFF = 2'b00,
        ST_P1       = 2'b01,
        ST_P2       = 2'b10,
        ST_DONE     = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10
    } winner_e;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;

    function automatic logic [2:0] die_next(input logic [2:0] d);
        return (d == DIE_MAX) ? DIE_MIN : d + 3'd1;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Roll button conditioning: 2-FF synchroniser, stability counter and
// a one-cycle pulse on each debounced press (active-low button).
module button_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        deb_d = deb_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
        press_d = deb_q & ~deb_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            deb_q   <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dice_scorekeeper.sv
// Dice game datapath: die counter, roll acceptance with turn lock,
// saturating per-player scores and sticky win detection.
module dice_scorekeeper
    import dice_pkg::*;
#(
    parameter int SCORE_W      = 6,
    parameter int WIN_SCORE    = 20,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic               clk,
    input  logic               power,
    input  logic [1:0]         state,
    input  logic               rollBtn,
    output logic [2:0]         dieValue,
    output logic [SCORE_W-1:0] p1Score,
    output logic [SCORE_W-1:0] p2Score,
    output logic               hasWon,
    output logic [1:0]         winner,
    output logic               rollPulse
);

    localparam logic [SCORE_W-1:0] WIN_TH = SCORE_W'(WIN_SCORE);

    logic               press;
    logic [2:0]         cnt_q, cnt_d;
    logic [2:0]         die_q, die_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic               won_q, won_d;
    logic [1:0]         winner_q, winner_d;
    logic               pulse_q, pulse_d;
    logic               lock_q, lock_d;
    logic [1:0]         st_prev_q;

    logic               in_turn, lock_eff, accept;
    logic [SCORE_W-1:0] cur, sat;
    logic [SCORE_W:0]   sum;

    button_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
        .clk  (clk),
        .rst_n(power),
        .btn_n(rollBtn),
        .press(press)
    );

    always_comb begin
        in_turn  = (state == ST_P1) || (state == ST_P2);
        // A state change releases the lock in the same cycle it is seen
        lock_eff = lock_q && (state == st_prev_q);
        accept   = press && in_turn && !lock_eff && !won_q;
        cur      = (state == ST_P2) ? p2_q : p1_q;
        sum      = {1'b0, cur} + {{(SCORE_W-2){1'b0}}, cnt_q};
        sat      = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

        cnt_d    = die_next(cnt_q);
        die_d    = die_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        won_d    = won_q;
        winner_d = winner_q;
        pulse_d  = accept;
        lock_d   = lock_eff;

        if (accept) begin
            die_d  = cnt_q;
            lock_d = 1'b1;
            if (state == ST_P2) p2_d = sat;
            else                p1_d = sat;
        end

        if (!won_q) begin
            if (p1_q >= WIN_TH) begin
                won_d    = 1'b1;
                winner_d = WIN_P1;
            end else if (p2_q >= WIN_TH) begin
                won_d    = 1'b1;
                winner_d = WIN_P2;
            end
        end

        if (state == ST_POWEROFF) begin
            die_d    = '0;
            p1_d     = '0;
            p2_d     = '0;
            won_d    = 1'b0;
            winner_d = WIN_NONE;
            lock_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            cnt_q     <= DIE_MIN;
            die_q     <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            won_q     <= 1'b0;
            winner_q  <= WIN_NONE;
            pulse_q   <= 1'b0;
            lock_q    <= 1'b0;
            st_prev_q <= ST_POWEROFF;
        end else begin
            cnt_q     <= cnt_d;
            die_q     <= die_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            won_q     <= won_d;
            winner_q  <= winner_d;
            pulse_q   <= pulse_d;
            lock_q    <= lock_d;
            st_prev_q <= state;
        end
    end

    assign dieValue  = die_q;
    assign p1Score   = p1_q;
    assign p2Score   = p2_q;
    assign hasWon    = won_q;
    assign winner    = winner_q;
    assign rollPulse = pulse_q;

endmodule

// File: tb/tb_dice_scorekeeper.sv
// Randomised bench for dice_scorekeeper: two configurations driven in
// parallel and compared against a behavioural game model every cycle.
module tb_dice_scorekeeper;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       power = 1'b0;
    logic [1:0] state = 2'b00;
    logic       rollBtn = 1'b1;

    logic [2:0] die0, die1;
    logic [5:0] p1s0, p2s0;
    logic [2:0] p1s1, p2s1;
    logic       won0, won1, pulse0, pulse1;
    logic [1:0] winr0, winr1;

    int n_chk = 0;
    int n_err = 0;

    dice_scorekeeper #(.SCORE_W(6), .WIN_SCORE(20), .DEBOUNCE_CYC(N)) u_dut0 (
        .clk(clk), .power(power), .state(state), .rollBtn(rollBtn),
        .dieValue(die0), .p1Score(p1s0), .p2Score(p2s0),
        .hasWon(won0), .winner(winr0), .rollPulse(pulse0)
    );

    dice_scorekeeper #(.SCORE_W(3), .WIN_SCORE(7), .DEBOUNCE_CYC(N)) u_dut1 (
        .clk(clk), .power(power), .state(state), .rollBtn(rollBtn),
        .dieValue(die1), .p1Score(p1s1), .p2Score(p2s1),
        .hasWon(won1), .winner(winr1), .rollPulse(pulse1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: game rules with plain integers and queues
    int  raw[$];
    int  hist[$];
    int  m_deb, m_press, m_cyc, m_prev;
    int  m_die[2], m_p1[2], m_p2[2], m_won[2], m_win[2], m_pulse[2], m_lock[2];
    int  smax[2] = '{63, 7};
    int  wsc[2]  = '{20, 7};
    int  rolls = 0;
    int  sats = 0;

    function automatic void model_reset();
        raw = '{1, 1};
        hist = {};
        for (int i = 0; i < N; i++) hist.push_back(1);
        m_deb = 1; m_press = 0; m_cyc = 0; m_prev = 0;
        for (int c = 0; c < 2; c++) begin
            m_die[c] = 0; m_p1[c] = 0; m_p2[c] = 0; m_won[c] = 0;
            m_win[c] = 0; m_pulse[c] = 0; m_lock[c] = 0;
        end
    endfunction

    function automatic void model_step();
        int samp, all_diff, press_now, die_now, changed, acc, sc;
        raw.push_front(int'(rollBtn));
        samp = raw[2];
        void'(raw.pop_back());
        hist.push_front(samp);
        void'(hist.pop_back());
        all_diff = 1;
        foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
        press_now = m_press;
        m_press = (all_diff != 0 && m_deb == 1) ? 1 : 0;
        if (all_diff != 0) m_deb = samp;
        die_now = (m_cyc % 6) + 1;
        m_cyc++;
        changed = (int'(state) != m_prev) ? 1 : 0;
        m_prev = int'(state);
        for (int c = 0; c < 2; c++) begin
            acc = (press_now != 0 && (state == 2'b01 || state == 2'b10) &&
                   !(m_lock[c] != 0 && changed == 0) && m_won[c] == 0) ? 1 : 0;
            if (m_won[c] == 0 && (m_p1[c] >= wsc[c] || m_p2[c] >= wsc[c])) begin
                m_won[c] = 1;
                m_win[c] = (m_p1[c] >= wsc[c]) ? 1 : 2;
            end
            if (changed != 0) m_lock[c] = 0;
            m_pulse[c] = acc;
            if (acc != 0) begin
                m_die[c] = die_now;
                m_lock[c] = 1;
                sc = ((state == 2'b10) ? m_p2[c] : m_p1[c]) + die_now;
                if (sc > smax[c]) begin
                    sc = smax[c];
                    if (c == 1) sats++;
                end
                if (state == 2'b10) m_p2[c] = sc;
                else                m_p1[c] = sc;
                if (c == 0) rolls++;
            end
            if (state == 2'b00) begin
                m_die[c] = 0; m_p1[c] = 0; m_p2[c] = 0;
                m_won[c] = 0; m_win[c] = 0; m_lock[c] = 0;
            end
        end
    endfunction

    task automatic compare_all();
        check("c0_die",   int'(die0),   m_die[0]);
        check("c0_p1",    int'(p1s0),   m_p1[0]);
        check("c0_p2",    int'(p2s0),   m_p2[0]);
        check("c0_won",   int'(won0),   m_won[0]);
        check("c0_winr",  int'(winr0),  m_win[0]);
        check("c0_pulse", int'(pulse0), m_pulse[0]);
        check("c1_die",   int'(die1),   m_die[1]);
        check("c1_p1",    int'(p1s1),   m_p1[1]);
        check("c1_p2",    int'(p2s1),   m_p2[1]);
        check("c1_won",   int'(won1),   m_won[1]);
        check("c1_winr",  int'(winr1),  m_win[1]);
        check("c1_pulse", int'(pulse1), m_pulse[1]);
    endtask

    task automatic tick();
        if (power) model_step();
        else       model_reset();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_btn(input int hold, input int gap);
        rollBtn = 1'b0;
        ticks(hold);
        rollBtn = 1'b1;
        ticks(gap);
    endtask

    initial begin
        model_reset();
        #1;
        compare_all();
        for (int i = 0; i < 6; i++) begin
            rollBtn = ~rollBtn;
            tick();
        end
        rollBtn = 1'b1;
        ticks(3);
        power = 1'b1;
        ticks(14);

        state = 2'b01;
        ticks(2);
        press_btn(10, 10);
        press_btn(8, 8);
        state = 2'b10;
        ticks(2);
        press_btn(6, 8);
        press_btn(N - 1, 8);
        state = 2'b01;
        press_btn(N - 1, 8);
        press_btn(N + 1, 8);
        state = 2'b11;
        press_btn(7, 8);
        state = 2'b00;
        ticks(3);

        for (int s = 0; s < 400; s++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                state = 2'b00;
                ticks(2);
            end else if (r == 1) begin
                state = 2'b11;
            end else if (r == 2) begin
                power = 1'b0;
                #1;
                model_reset();
                compare_all();
                ticks(2);
                power = 1'b1;
            end else if (r < 6) begin
                rollBtn = $urandom_range(0, 1) != 0;
                tick();
            end else begin
                state = (state == 2'b01) ? 2'b10 : 2'b01;
            end
            press_btn($urandom_range(1, 10), $urandom_range(3, 12));
        end

        check("rolls_seen", int'(rolls > 20), 1);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/dice_scorekeeper.md
Name: dice_scorekeeper

Overview:
- Other end of the game-state interface: consumes the 2-bit `state` from the turn state machine and produces the `hasWon` input that it samples.
- Debounces and edge-detects the roll pushbutton and generates die values 1..6.
- Accumulates per-player scores, detects the winner, and drives display-ready outputs.
- Sits between the board buttons/switches and the state machine.

Parameters:
- SCORE_W, 6, width of each player score register.
- WIN_SCORE, 20, score at or above which a player wins; must be < 2^SCORE_W.
- DEBOUNCE_CYC, 4, consecutive stable samples required before the debounced button changes; must be >= 1.

Ports:
- clk  input  1  system clock.
- power  input  1  asynchronous active-low reset (SW[0]); low forces every register to its reset value.
- state  input  2  game state: 00 powerOff, 01 p1Turn, 10 p2Turn, 11 gameFinished.
- rollBtn  input  1  roll pushbutton, active-low, asynchronous to clk.
- dieValue  output  3  last rolled value 1..6; 0 = no roll since clear.
- p1Score  output  SCORE_W  player 1 accumulated score.
- p2Score  output  SCORE_W  player 2 accumulated score.
- hasWon  output  1  high when either score >= WIN_SCORE; sticky until clear.
- winner  output  2  00 none, 01 player 1, 10 player 2.
- rollPulse  output  1  one-cycle strobe on each accepted roll.

Behaviour:
- Reset (power low, async): dieValue=0, p1Score=0, p2Score=0, hasWon=0, winner=00, rollPulse=0, die counter=1, sync/debounce regs=1 (released), turn lock=0.
- Die counter: free-running and advances every clk. Sequence 1,2,3,4,5,6,1,... The value 0 or 7 never occurs.
- Button path:
  - 2-FF synchroniser feeds the debouncer.
  - Debounced level changes only after DEBOUNCE_CYC consecutive equal synchronised samples.
  - `press` = debounced 1->0 transition, one cycle wide.
- Roll acceptance: a roll is accepted in cycle t when all of the following hold: press=1, state is 01 or 10, lock=0, hasWon=0.
- On an accepted roll, registered at t+1:
  - dieValue <= counter value at t.
  - Current player's score <= min(score + die, 2^SCORE_W-1), computed at SCORE_W+1 bits, then saturated.
  - rollPulse=1 for exactly that cycle.
  - lock <= 1.
- Turn lock: cleared when `state` differs from its value in the previous cycle. This prevents double-scoring during the state machine's 2-cycle output lag.
- Press ignored (no score change, no rollPulse):
  - while state is 00 or 11;
  - while lock=1;
  - while hasWon=1.
- Win detect:
  - hasWon <= (p1Score >= WIN_SCORE) | (p2Score >= WIN_SCORE), registered, so it rises one cycle after the score update.
  - winner is set in the same cycle from whichever score crossed the threshold. Only one score can change per cycle, so there are no ties.
- Clear: while state==00, scores, dieValue, hasWon, winner and lock return to reset values synchronously. The counter keeps running.
- Simultaneous press and state change in the same cycle: the lock clears, and the press is evaluated against the new state.
- Reset mid-debounce: debounced level returns to released, and no press is generated on release of power.

Decomposition:
- Shared package `dice_pkg`:
  - state encodings ST_POWEROFF=2'b00, ST_P1=2'b01, ST_P2=2'b10, ST_DONE=2'b11 (also used by the state machine);
  - winner encodings WIN_NONE, WIN_P1, WIN_P2;
  - DIE_MIN=1, DIE_MAX=6.
- One sub-module, `button_debounce`: synchroniser, debounce counter and falling-edge pulse, parameterised by DEBOUNCE_CYC, clocked by clk and reset by power.

Test Plan:
- Reset: hold power=0 with rollBtn toggling -> all outputs 0, winner=00. Release power with state=00 -> outputs stay 0 and the counter advances 1..6 and wraps.
- Single roll: state=01, press rollBtn held 10 cycles -> exactly one rollPulse. dieValue equals the counter value in the press cycle. p1Score = dieValue, p2Score = 0.
- Lock: state held at 01 and press twice -> second press ignored, p1Score unchanged. Set state to 10 and press -> p2Score updated, rollPulse once.
- Bounce: rollBtn glitches low for DEBOUNCE_CYC-1 cycles -> no press, no rollPulse. A clean press afterwards is accepted.
- Win:
  - preload p1Score=18 via rolls, then roll 3 -> p1Score=21; hasWon=1 and winner=01 one cycle later;
  - further presses with state=01/10/11 -> no score change;
  - state=00 -> all clear.
- Saturation and ignore: SCORE_W=3, WIN_SCORE=7, score 6 + roll 5 -> score 7 (saturated). Press in state 11 -> ignored. Power low mid-game -> immediate async clear.
